// File: rtl/fifo_arb_pkg.sv
// Shared types, default sizes and helpers for the FIFO write-port arbiter family.
package fifo_arb_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  // Modulo-n increment of a round-robin pointer.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N. Shared by write-side and future read-side arbiters.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    int j;
    j   = 0;
    idx = '0;
    any = |req;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) idx = IDX_W'(j);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync-FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester accept and stall counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         data_in,
  output logic                      wr_en,
  input  logic                      full,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     accept_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       state, state_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_valid;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_valid = req_valid[owner];

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    burst_cnt_nxt = burst_cnt;
    grant         = '0;
    busy          = 1'b0;
    req_ready     = '0;
    wr_en         = 1'b0;
    data_in       = '0;

    case (state)
      IDLE: begin
        if (pick_any) begin
          owner_nxt     = pick_idx;
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        busy             = 1'b1;
        grant[owner]     = 1'b1;
        req_ready[owner] = !full;
        wr_en            = owner_valid && !full;
        if (wr_en) begin
          data_in       = req_data[int'(owner)*DATA_W +: DATA_W];
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
        // Full only stalls; the grant is released by a dropped valid or a full burst.
        if ((wr_en && burst_cnt == CNT_W'(MAX_BURST - 1)) || !owner_valid) begin
          state_nxt = IDLE;
          ptr_nxt   = PTR_W'(rr_next(int'(owner), NUM_REQ));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (wr_en)
        accept_cnt[int'(owner)*32 +: 32] <= accept_cnt[int'(owner)*32 +: 32] + 32'd1;
      if (busy && owner_valid && full)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers feed per-requester queues,
// expected writes are queued by hand and a negedge monitor compares every write.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  typedef struct {
    int          req;
    logic [31:0] data;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     data_in;
  logic              wr_en;
  logic              full;
  logic [NR-1:0]     grant;
  logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*32-1:0]  accept_cnt;
  logic [31:0]       stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .data_in   (data_in),
    .wr_en     (wr_en),
    .full      (full),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .accept_cnt(accept_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] src_q [NR][$];
  exp_t        exp_q [$];
  int          wr_cyc_q [$];
  logic [NR-1:0] hs;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NR; i++)
      if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic expect_word(input int r, input logic [31:0] d);
    exp_t e;
    e.req  = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Producers: handshake sampled mid-cycle, queues popped just after the edge.
  always @(negedge clk) hs = req_valid & req_ready & ~{NR{rst}};

  always @(posedge clk) begin
    #2;
    if (!rst)
      for (int i = 0; i < NR; i++)
        if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = (src_q[i].size() != 0);
      req_data[i*DW +: DW]   = (src_q[i].size() != 0) ? src_q[i][0] : 32'h0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
      check("ready_only_owner", 64'(req_ready & ~grant), 64'd0);
      if (!busy) check("grant_idle_zero", 64'(grant), 64'd0);
      if (wr_en) begin
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(data_in), 64'hdead_beef);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_data", 64'(data_in), 64'(e.data));
          check("wr_grant", 64'(grant), 64'(4'b0001 << e.req));
        end
      end else begin
        check("data_idle_zero", 64'(data_in), 64'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && src_empty() && !busy) && n < 300) begin
      step();
      n++;
    end
    check({name, "_drain_in_time"}, 64'(n < 300), 64'd1);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_wr_en"}, 64'(wr_en), 64'd0);
    check({name, "_grant"}, 64'(grant), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_ready"}, 64'(req_ready), 64'd0);
    check({name, "_data"}, 64'(data_in), 64'd0);
  endtask

  initial begin
    int base, start;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, start;
    rst       = 1'b1;
    full      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_ptr", 64'(dut.ptr), 64'd0);
    rst = 1'b0;
    step();

    // All four requesters continuously valid: order 0,1,2,3,0.
    base  = wr_cyc_q.size();
    start = cyc;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < 4; k++) begin
        src_q[r].push_back(32'((r << 28) | k));
        expect_word(r, 32'((r << 28) | k));
      end
    for (int k = 4; k < 8; k++) begin
      src_q[0].push_back(32'(k));
      expect_word(0, 32'(k));
    end
    drain("rr4");
    check("rr4_first_write_cyc", 64'(wr_cyc_q[base] - start), 64'd1);
    check("rr4_16th_write_cyc", 64'(wr_cyc_q[base+15] - start), 64'd19);
    check("rr4_20th_write_cyc", 64'(wr_cyc_q[base+19] - start), 64'd24);
    check("rr4_ptr", 64'(dut.ptr), 64'd1);

    // Req0 alone, three words then valid drops.
    base  = wr_cyc_q.size();
    start = cyc;
    src_q[0].push_back(32'hA); expect_word(0, 32'hA);
    src_q[0].push_back(32'hB); expect_word(0, 32'hB);
    src_q[0].push_back(32'hC); expect_word(0, 32'hC);
    drain("req0");
    check("req0_write_count", 64'(wr_cyc_q.size() - base), 64'd3);
    check("req0_w0_cyc", 64'(wr_cyc_q[base]   - start), 64'd1);
    check("req0_w2_cyc", 64'(wr_cyc_q[base+2] - start), 64'd3);
    check("req0_idle_busy", 64'(busy), 64'd0);
    check("req0_ptr", 64'(dut.ptr), 64'd1);

    // Req2 burst stalled by full for 5 cycles after the second word.
    base  = wr_cyc_q.size();
    start = cyc;
    for (int k = 0; k < 4; k++) begin
      src_q[2].push_back(32'h2000_0100 + 32'(k));
      expect_word(2, 32'h2000_0100 + 32'(k));
    end
    repeat (3) step();
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("full_wr_en", 64'(wr_en), 64'd0);
      check("full_ready", 64'(req_ready), 64'd0);
      check("full_grant", 64'(grant), 64'b0100);
      check("full_burst_cnt", 64'(dut.burst_cnt), 64'd2);
      step();
    end
    full = 1'b0;
    drain("full");
    check("full_write_count", 64'(wr_cyc_q.size() - base), 64'd4);
    check("full_w1_cyc", 64'(wr_cyc_q[base+1] - start), 64'd2);
    check("full_w2_cyc", 64'(wr_cyc_q[base+2] - start), 64'd8);
    check("full_ptr", 64'(dut.ptr), 64'd3);

    // ptr=3 with only req1 and req3 valid: req3 first, then req1.
    src_q[1].push_back(32'h1111_0000); src_q[1].push_back(32'h1111_0001);
    src_q[3].push_back(32'h3333_0000); src_q[3].push_back(32'h3333_0001);
    expect_word(3, 32'h3333_0000); expect_word(3, 32'h3333_0001);
    expect_word(1, 32'h1111_0000); expect_word(1, 32'h1111_0001);
    drain("wrap");
    check("wrap_ptr", 64'(dut.ptr), 64'd2);

    // Reset mid-burst (owner 2, burst_cnt 1), then req0 wins after reset.
    for (int k = 0; k < 4; k++) src_q[2].push_back(32'h2200_0000 + 32'(k));
    src_q[0].push_back(32'h0E00_0000);
    expect_word(2, 32'h2200_0000);
    repeat (2) step();
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_grant", 64'(grant), 64'b0100);
    check("mid_burst_cnt", 64'(dut.burst_cnt), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    expect_word(0, 32'h0E00_0000);
    for (int k = 1; k < 4; k++) expect_word(2, 32'h2200_0000 + 32'(k));
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    drain("post_rst");

`ifdef FIFO_WR_ARB_STATS_EN
    // Counters: 12 words per requester, full asserted for 3 BURST cycles.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NR; i++)
        for (int k = 0; k < 4; k++) begin
          src_q[i].push_back(32'((i << 28) | (r << 4) | k));
          expect_word(i, 32'((i << 28) | (r << 4) | k));
        end
    repeat (41) step();
    full = 1'b1;
    repeat (3) step();
    full = 1'b0;
    drain("stats");
    for (int i = 0; i < NR; i++)
      check("stats_accept_cnt", 64'(accept_cnt[i*32 +: 32]), 64'd12);
    check("stats_stall_cnt", 64'(stall_cnt), 64'd3);
`endif

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the single write port of the 32-bit sync FIFO (data_in/wr_en/full) among NUM_REQ producers.
- Grants one producer at a time for a bounded burst, then rotates priority.
- Sits between producer blocks and the FIFO write side. The read side of the FIFO is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 32, data width; matches FIFO data_in
- MAX_BURST, 4, maximum words per grant (>=1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester word valid
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  per-requester accept; word transfers when valid&&ready
- data_in  output  DATA_W  FIFO write data
- wr_en  output  1  FIFO write enable
- full  input  1  FIFO full flag
- grant  output  NUM_REQ  one-hot current owner; all zero in IDLE
- busy  output  1  high in BURST state

Behaviour:
- Reset:
  - State=IDLE, ptr=0, owner=0, burst_cnt=0.
  - All outputs are 0 immediately on rst assertion: wr_en, data_in, req_ready, grant, busy.
- Registered state: state {IDLE,BURST}, owner, ptr (both $clog2(NUM_REQ) bits), burst_cnt ($clog2(MAX_BURST+1) bits). All other outputs are combinational from these registers and the inputs.
- IDLE:
  - No writes; req_ready=0.
  - If any req_valid: owner <= first asserted index searching ptr, ptr+1, ... wrapping mod NUM_REQ. Then state<=BURST, burst_cnt<=0.
  - This gives exactly one bubble cycle per grant.
- BURST:
  - grant=onehot(owner), busy=1.
  - req_ready[owner] = !full; all other ready bits are 0.
  - wr_en = req_valid[owner] && !full.
  - data_in = req_data[owner] when wr_en=1, else 0.
  - Accept (wr_en=1): burst_cnt++.
  - Exit to IDLE, with ptr <= (owner+1) mod NUM_REQ, when either:
    - accept && burst_cnt==MAX_BURST-1, or
    - !req_valid[owner].
- Latency: data_in/wr_en follow req_data/req_valid in the same cycle (zero latency). The FIFO write occurs at the next clk edge.
- full: while full=1, wr_en=0 and req_ready=0. Owner is kept and burst_cnt holds; there is no timeout. full dropping resumes the burst in the same cycle.
- Requester contract: req_data is stable while valid && !ready. Dropping valid releases the grant.
- Non-owner valid never causes a write.
- Wrap-around: the priority search and ptr increment are modulo NUM_REQ; ptr=NUM_REQ-1 wraps to 0.
- Reset mid-burst: the burst is abandoned with no partial write. The next grant after reset starts at requester 0.
- A single requester running continuously receives MAX_BURST words, then one IDLE cycle, then is re-granted.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- Defined: adds these ports:
  - accept_cnt (output, NUM_REQ*32): per-requester count of accepted words.
  - stall_cnt (output, 32): cycles in BURST with req_valid[owner]&&full.
  - Both counters clear on rst, wrap modulo 2^32, and are non-saturating.
- Not defined: the ports and counters are absent. Base behaviour is identical in both builds.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum arb_state_e {IDLE,BURST};
  - default constants DATA_W_DEF=32, NUM_REQ_DEF=4, MAX_BURST_DEF=4;
  - a function rr_next(ptr) for modulo increment.
- One sub-module rr_pick: combinational round-robin picker. Inputs are req vector and ptr; outputs are index and any. Reused by future read-side arbiters.

Test Plan:
- Req0 only, 3 words 0xA,0xB,0xC, then valid drops → 1 IDLE cycle; wr_en high for 3 consecutive cycles with data_in A,B,C; return to IDLE; ptr=1.
- All 4 requesters valid continuously, MAX_BURST=4, full=0 → grant order 0,1,2,3,0; 4 words per grant; 16 writes in 20 cycles; never two grant bits high.
- Req2 in burst, full=1 for 5 cycles after the 2nd word → wr_en=0 and req_ready=0 for those 5 cycles; burst_cnt holds at 2; 2 more words after release; total 4; no write while full.
- ptr=3, only req1 and req3 valid → req3 granted first, then req1, then ptr=2.
- rst pulsed mid-burst (owner=2, burst_cnt=1) → wr_en/grant/busy 0 immediately; after release, req0 granted first if valid.
- FIFO_WR_ARB_STATS_EN defined, repeat scenario 2 for 40 cycles plus 3 full cycles → each accept_cnt equals words written per requester; stall_cnt=3.
